// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, shift, flag and FSM encodings for alu_seq
package alu_pkg;

  // Opcodes; 8-15 are illegal and complete with out_err set.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;

  // Operand-2 pre-shift selects.
  localparam logic [1:0] SR_NONE = 2'd0;
  localparam logic [1:0] SR_LSR  = 2'd1;
  localparam logic [1:0] SR_LSL  = 2'd2;
  localparam logic [1:0] SR_ROR  = 2'd3;

  // Bit positions inside the {N,Z,C,V} flags register.
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative unsigned shift-add multiplier, one multiplier bit per cycle
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (aborts any run)
//   start       load a/b and begin; only honoured by the caller while idle
//   a, b        multiplicand and multiplier
//   busy        a multiplication is in progress
//   done        this cycle performs the final step; product is valid now
//   product     low WIDTH bits of a*b, combinational view of the final step
module alu_seq_mul #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step;

  always_comb begin
    step     = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      // WIDTH is a power of two, so the last step is at the all-ones count.
      if (cnt_q == '1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '1);
  assign product = step;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with operand-2 barrel pre-shift, NZCV flags and iterative MUL
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid/in_ready    operation handshake (accept on in_valid & in_ready)
//   opcode, in1, in2     operation and operands (in2 before the shift)
//   sr_cont, sr_amt      pre-shift select and amount for in2
//   set_flags            write NZCV with this operation (CMP always writes)
//   out_valid/out_ready  result handshake
//   result, out_err      registered result and illegal-opcode marker
//   flags                {N,Z,C,V} register
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       sr_cont,
  input  logic [SHW-1:0]   sr_amt,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err,
  output logic [3:0]       flags
);

  alu_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_err_q, out_err_d;
  logic [3:0]       flags_q, flags_d;
  logic             mul_sf_q, mul_sf_d;

  logic             accept;
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  // Pre-shifter on operand 2.
  logic [WIDTH-1:0] op_b;
  logic             sh_act, sh_c;
  logic [SHW-1:0]   amt_m1, amt_neg;

  always_comb begin
    amt_m1  = sr_amt - SHW'(1);
    amt_neg = SHW'(0) - sr_amt;
    sh_act  = (sr_cont != SR_NONE) && (sr_amt != '0);
    op_b    = in2;
    sh_c    = 1'b0;
    if (sh_act) begin
      case (sr_cont)
        SR_LSR: begin
          op_b = in2 >> sr_amt;
          sh_c = in2[amt_m1];
        end
        SR_LSL: begin
          op_b = in2 << sr_amt;
          // Last bit out of the top is in2[WIDTH-amt]; WIDTH-1 is all ones.
          sh_c = in2[~amt_m1];
        end
        default: begin
          op_b = (in2 >> sr_amt) | (in2 << amt_neg);
          sh_c = in2[amt_m1];
        end
      endcase
    end
  end

  // Single-cycle datapath; subtraction is in1 + ~B + 1 so C means "no borrow".
  logic [WIDTH:0]   add_full, sub_full;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  always_comb begin
    add_full = {1'b0, in1} + {1'b0, op_b};
    sub_full = {1'b0, in1} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    add_v    = (in1[WIDTH-1] == op_b[WIDTH-1]) && (add_full[WIDTH-1] != in1[WIDTH-1]);
    sub_v    = (in1[WIDTH-1] != op_b[WIDTH-1]) && (sub_full[WIDTH-1] != in1[WIDTH-1]);
    alu_res  = '0;
    alu_c    = flags_q[FLG_C];
    alu_v    = flags_q[FLG_V];
    case (opcode)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = sub_v;
      end
      OP_OR: begin
        alu_res = in1 | op_b;
        if (sh_act) alu_c = sh_c;
      end
      OP_AND: begin
        alu_res = in1 & op_b;
        if (sh_act) alu_c = sh_c;
      end
      OP_XOR: begin
        alu_res = in1 ^ op_b;
        if (sh_act) alu_c = sh_c;
      end
      OP_MOV: begin
        alu_res = op_b;
        if (sh_act) alu_c = sh_c;
      end
      default: alu_res = '0;
    endcase
    alu_flags        = '0;
    alu_flags[FLG_N] = alu_res[WIDTH-1];
    alu_flags[FLG_Z] = (alu_res == '0);
    alu_flags[FLG_C] = alu_c;
    alu_flags[FLG_V] = alu_v;
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (in1),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    out_err_d   = out_err_q;
    flags_d     = flags_q;
    mul_sf_d    = mul_sf_q;
    if (accept) begin
      if (opcode == OP_MUL) begin
        state_d  = ST_MUL_BUSY;
        mul_sf_d = set_flags;
      end else if (opcode > OP_MOV) begin
        result_d    = '0;
        out_err_d   = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        result_d    = alu_res;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        if (set_flags || (opcode == OP_CMP)) flags_d = alu_flags;
      end
    end else if ((state_q == ST_MUL_BUSY) && mul_done) begin
      state_d     = ST_IDLE;
      result_d    = mul_product;
      out_err_d   = 1'b0;
      out_valid_d = 1'b1;
      if (mul_sf_q) begin
        flags_d[FLG_N] = mul_product[WIDTH-1];
        flags_d[FLG_Z] = (mul_product == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_err_q   <= 1'b0;
      flags_q     <= 4'b0000;
      mul_sf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_err_q   <= out_err_d;
      flags_q     <= flags_d;
      mul_sf_q    <= mul_sf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_err   = out_err_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] in1, in2;
  logic [1:0]  sr_cont;
  logic [4:0]  sr_amt;
  logic        set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_err;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .in1       (in1),
    .in2       (in2),
    .sr_cont   (sr_cont),
    .sr_amt    (sr_amt),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_err   (out_err),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an op at posedge+1, wait (bounded) for in_ready, return at posedge+1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] sc, input logic [4:0] amt, input logic sf);
    int n;
    opcode    = op;
    in1       = a;
    in2       = b;
    sr_cont   = sc;
    sr_amt    = amt;
    set_flags = sf;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int low_cnt;
    logic early, seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; in1 = '0; in2 = '0; sr_cont = '0; sr_amt = '0; set_flags = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_err", out_err, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);

    // ADD overflow into the sign bit.
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, SR_NONE, 5'd0, 1'b1);
    check("add_valid", out_valid, 1);
    check("add_result", result, 32'h8000_0000);
    check("add_flags", flags, 4'b1001);

    // MOV with ROR 1: carry is the rotated-out bit 0; V stays 1.
    issue(OP_MOV, 32'h0, 32'h8000_0001, SR_ROR, 5'd1, 1'b1);
    check("mov_ror_result", result, 32'hC000_0000);
    check("mov_ror_flags", flags, 4'b1011);

    // SUB with borrow: 3-5.
    issue(OP_SUB, 32'd3, 32'd5, SR_NONE, 5'd0, 1'b1);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_flags", flags, 4'b1000);

    // OR with LSR 1 of 3: B=1, carry out=1.
    issue(OP_OR, 32'h0, 32'h3, SR_LSR, 5'd1, 1'b1);
    check("or_lsr_result", result, 32'h1);
    check("or_lsr_flags", flags, 4'b0010);

    // CMP updates flags even with set_flags=0.
    issue(OP_CMP, 32'd5, 32'd5, SR_NONE, 5'd0, 1'b0);
    check("cmp_valid", out_valid, 1);
    check("cmp_result", result, 32'h0);
    check("cmp_flags", flags, 4'b0110);

    // AND without set_flags leaves flags alone.
    issue(OP_AND, 32'hFF, 32'h0F, SR_NONE, 5'd0, 1'b0);
    check("and_result", result, 32'h0F);
    check("and_flags", flags, 4'b0110);

    // MOV with LSL 1: carry is old bit 31.
    issue(OP_MOV, 32'h0, 32'hC000_0000, SR_LSL, 5'd1, 1'b1);
    check("mov_lsl_result", result, 32'h8000_0000);
    check("mov_lsl_flags", flags, 4'b1010);

    // MUL 1234 * (3 LSL 2) = 14808, latency 32, operands changed while busy.
    issue(OP_MUL, 32'd1234, 32'd3, SR_LSL, 5'd2, 1'b1);
    in1 = 32'hDEAD_BEEF; in2 = 32'h0; set_flags = 1'b0;
    low_cnt = 0; early = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!in_ready) low_cnt++;
      if (out_valid) early = 1'b1;
      @(posedge clk); #1;
    end
    check("mul_ready_low_cycles", low_cnt, 32);
    check("mul_no_early_valid", early, 0);
    check("mul_valid", out_valid, 1);
    check("mul_result", result, 32'd14808);
    check("mul_flags", flags, 4'b0010);
    check("mul_ready_after", in_ready, 1);

    // Back-pressure: hold out_ready low after an ADD.
    issue(OP_ADD, 32'd2, 32'd3, SR_NONE, 5'd0, 1'b0);
    out_ready = 1'b0;
    opcode = OP_XOR; in1 = 32'hA5; in2 = 32'hFF; sr_cont = SR_NONE; sr_amt = '0; set_flags = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", result, 32'd5);
      check("bp_hold_ready", in_ready, 0);
    end
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_same_cycle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_result", result, 32'h5A);

    // Illegal opcode.
    issue(4'hF, 32'h1234, 32'h5678, SR_NONE, 5'd0, 1'b1);
    check("ill_err", out_err, 1);
    check("ill_result", result, 32'h0);
    check("ill_valid", out_valid, 1);
    check("ill_flags", flags, 4'b0010);
    issue(OP_ADD, 32'd1, 32'd1, SR_NONE, 5'd0, 1'b0);
    check("legal_clears_err", out_err, 0);
    check("legal_result", result, 32'd2);

    // Reset in the middle of a MUL.
    issue(OP_MUL, 32'd7, 32'd9, SR_NONE, 5'd0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_flags", flags, 0);
    check("mrst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mrst_no_result", seen, 0);
    check("mrst_ready_after", in_ready, 1);
    check("mrst_result", result, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
